// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU pipeline stages.
package mips_cpu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);

    typedef enum logic [2:0] {
        ALUTYPE_NOP,
        ALUTYPE_ARITH,
        ALUTYPE_LOGIC,
        ALUTYPE_MOVE,
        ALUTYPE_SHIFT
    } alutype_enum;

    typedef enum logic [3:0] {
        ALU_EMPTY,
        ALU_ADD,
        ALU_SUB,
        ALU_LT,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_LL,
        ALU_RL,
        ALU_RA,
        ALU_HI,
        ALU_LO,
        ALU_MULT,
        ALU_DIV
    } aluop_enum;

    typedef struct packed {
        logic      sign;
        aluop_enum op;
    } aluop_struct;

    typedef logic [4:0] reg_enum;

    typedef struct packed {
        logic       load;
        logic       store;
        logic [1:0] size;
        logic       sext;
    } memop_struct;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_enum;

    // Two's-complement negate when neg is set; used for abs() and result sign fix-up.
    function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes, sign fixed up on output.
module div_iter
    import mips_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sign,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    div_state_enum     state;
    div_state_enum     state_nxt;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvsr;
    logic              neg_q;
    logic              neg_r;

    logic [DATA_W:0]   step_trial;
    logic [DATA_W:0]   step_diff;
    logic              step_ge;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Divide by zero skips the iteration entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : BUSY;
            BUSY:    if (count == CNT_W'(DIV_CYCLES - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == BUSY);
        done      = (state == DONE);
        quotient  = cond_neg(neg_q, quo);
        remainder = cond_neg(neg_r, rem);
    end

    // Shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        step_trial = {rem, quo[DATA_W-1]};
        step_diff  = step_trial - {1'b0, dvsr};
        step_ge    = ~step_diff[DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            quo   <= '0;
            rem   <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            count <= '0;
            if (divisor == '0) begin
                quo   <= '1;
                rem   <= dividend;
                dvsr  <= '0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                quo   <= cond_neg(sign & dividend[DATA_W-1], dividend);
                rem   <= '0;
                dvsr  <= cond_neg(sign & divisor[DATA_W-1], divisor);
                neg_q <= sign & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                neg_r <= sign & dividend[DATA_W-1];
            end
        end else if (state == BUSY) begin
            count <= CNT_W'(count + CNT_W'(1));
            rem   <= step_ge ? step_diff[DATA_W-1:0] : step_trial[DATA_W-1:0];
            quo   <= {quo[DATA_W-2:0], step_ge};
        end
    end

endmodule

// File: rtl/stage_exe.sv
// Execute stage: single-cycle ALU and multiplier, iterative divider with pipeline stall.
module stage_exe
    import mips_cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  alutype_enum         exe_i_alutype,
    input  aluop_struct         exe_i_aluop,
    input  logic [DATA_W-1:0]   exe_i_src1,
    input  logic [DATA_W-1:0]   exe_i_src2,
    input  logic                exe_i_rfwe,
    input  reg_enum             exe_i_rfwa,
    input  logic                exe_i_hilowe,
    input  logic                exe_i_dm2rf,
    input  logic [DATA_W-1:0]   exe_i_dmdin,
    input  memop_struct         exe_i_memop,
    input  logic [DATA_W-1:0]   hi_i,
    input  logic [DATA_W-1:0]   lo_i,
    output logic                exe_o_rfwe,
    output reg_enum             exe_o_rfwa,
    output logic                exe_o_dm2rf,
    output logic [DATA_W-1:0]   exe_o_dmdin,
    output memop_struct         exe_o_memop,
    output logic [DATA_W-1:0]   exe_o_wd,
    output logic                exe_o_hilowe,
    output logic [2*DATA_W-1:0] exe_o_hilo,
    output logic                exe_o_stallreq
);

    logic              is_nop;
    logic              is_mult;
    logic              is_div;
    logic              div_busy;
    logic              div_done;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_rem;
    logic [4:0]        shamt;
    logic              lt;
    logic [2*DATA_W-1:0] prod;

    assign exe_o_rfwe  = exe_i_rfwe;
    assign exe_o_rfwa  = exe_i_rfwa;
    assign exe_o_dm2rf = exe_i_dm2rf;
    assign exe_o_dmdin = exe_i_dmdin;
    assign exe_o_memop = exe_i_memop;

    assign is_nop  = (exe_i_alutype == ALUTYPE_NOP);
    assign is_mult = is_nop && (exe_i_aluop.op == ALU_MULT);
    assign is_div  = is_nop && (exe_i_aluop.op == ALU_DIV);
    assign shamt   = exe_i_src1[4:0];

    div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div),
        .sign      (exe_i_aluop.sign),
        .dividend  (exe_i_src1),
        .divisor   (exe_i_src2),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        lt   = exe_i_aluop.sign ? ($signed(exe_i_src1) < $signed(exe_i_src2))
                                : (exe_i_src1 < exe_i_src2);
        prod = exe_i_aluop.sign
             ? 64'($signed(64'($signed(exe_i_src1))) * $signed(64'($signed(exe_i_src2))))
             : 64'(64'(exe_i_src1) * 64'(exe_i_src2));
    end

    always_comb begin
        exe_o_wd = '0;
        case (exe_i_alutype)
            ALUTYPE_ARITH: begin
                case (exe_i_aluop.op)
                    ALU_ADD: exe_o_wd = exe_i_src1 + exe_i_src2;
                    ALU_SUB: exe_o_wd = exe_i_src1 - exe_i_src2;
                    ALU_LT:  exe_o_wd = {31'b0, lt};
                    default: exe_o_wd = '0;
                endcase
            end
            ALUTYPE_LOGIC: begin
                case (exe_i_aluop.op)
                    ALU_AND: exe_o_wd = exe_i_src1 & exe_i_src2;
                    ALU_OR:  exe_o_wd = exe_i_src1 | exe_i_src2;
                    ALU_XOR: exe_o_wd = exe_i_src1 ^ exe_i_src2;
                    ALU_NOR: exe_o_wd = ~(exe_i_src1 | exe_i_src2);
                    default: exe_o_wd = '0;
                endcase
            end
            ALUTYPE_SHIFT: begin
                case (exe_i_aluop.op)
                    ALU_LL:  exe_o_wd = exe_i_src2 << shamt;
                    ALU_RL:  exe_o_wd = exe_i_src2 >> shamt;
                    ALU_RA:  exe_o_wd = 32'($signed(exe_i_src2) >>> shamt);
                    default: exe_o_wd = '0;
                endcase
            end
            ALUTYPE_MOVE: begin
                case (exe_i_aluop.op)
                    ALU_HI:  exe_o_wd = hi_i;
                    ALU_LO:  exe_o_wd = lo_i;
                    default: exe_o_wd = '0;
                endcase
            end
            default: exe_o_wd = '0;
        endcase
    end

    // HI/LO is only written by a DIV once its result is final.
    always_comb begin
        exe_o_hilo     = '0;
        exe_o_hilowe   = exe_i_hilowe;
        exe_o_stallreq = 1'b0;
        if (is_nop) begin
            exe_o_hilowe = 1'b0;
            if (is_mult) begin
                exe_o_hilo   = prod;
                exe_o_hilowe = exe_i_hilowe;
            end else if (is_div) begin
                exe_o_hilo     = {div_rem, div_quo};
                exe_o_hilowe   = div_done & exe_i_hilowe;
                exe_o_stallreq = div_busy | ~div_done;
            end
        end
        if (rst) begin
            exe_o_hilowe   = 1'b0;
            exe_o_stallreq = 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_exe.sv
// Directed self-checking bench for stage_exe: ALU ops, multiply, iterative divide, reset abort.
module tb_stage_exe;
    import mips_cpu_pkg::*;

    logic         clk;
    logic         rst;
    alutype_enum  exe_i_alutype;
    aluop_struct  exe_i_aluop;
    logic [31:0]  exe_i_src1;
    logic [31:0]  exe_i_src2;
    logic         exe_i_rfwe;
    reg_enum      exe_i_rfwa;
    logic         exe_i_hilowe;
    logic         exe_i_dm2rf;
    logic [31:0]  exe_i_dmdin;
    memop_struct  exe_i_memop;
    logic [31:0]  hi_i;
    logic [31:0]  lo_i;
    logic         exe_o_rfwe;
    reg_enum      exe_o_rfwa;
    logic         exe_o_dm2rf;
    logic [31:0]  exe_o_dmdin;
    memop_struct  exe_o_memop;
    logic [31:0]  exe_o_wd;
    logic         exe_o_hilowe;
    logic [63:0]  exe_o_hilo;
    logic         exe_o_stallreq;

    int checks;
    int errors;

    stage_exe dut (
        .clk            (clk),
        .rst            (rst),
        .exe_i_alutype  (exe_i_alutype),
        .exe_i_aluop    (exe_i_aluop),
        .exe_i_src1     (exe_i_src1),
        .exe_i_src2     (exe_i_src2),
        .exe_i_rfwe     (exe_i_rfwe),
        .exe_i_rfwa     (exe_i_rfwa),
        .exe_i_hilowe   (exe_i_hilowe),
        .exe_i_dm2rf    (exe_i_dm2rf),
        .exe_i_dmdin    (exe_i_dmdin),
        .exe_i_memop    (exe_i_memop),
        .hi_i           (hi_i),
        .lo_i           (lo_i),
        .exe_o_rfwe     (exe_o_rfwe),
        .exe_o_rfwa     (exe_o_rfwa),
        .exe_o_dm2rf    (exe_o_dm2rf),
        .exe_o_dmdin    (exe_o_dmdin),
        .exe_o_memop    (exe_o_memop),
        .exe_o_wd       (exe_o_wd),
        .exe_o_hilowe   (exe_o_hilowe),
        .exe_o_hilo     (exe_o_hilo),
        .exe_o_stallreq (exe_o_stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input alutype_enum t, input aluop_enum op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b);
        exe_i_alutype    = t;
        exe_i_aluop.op   = op;
        exe_i_aluop.sign = sgn;
        exe_i_src1       = a;
        exe_i_src2       = b;
    endtask

    task automatic alu(input string tag, input alutype_enum t, input aluop_enum op, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        set_op(t, op, sgn, a, b);
        #1;
        check(tag, 64'(exe_o_wd), 64'(exp));
        next_cycle();
    endtask

    // Runs one DIV from IDLE; optionally perturbs the operands while the divider is busy.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_hilo, input int exp_stall, input int corrupt_at);
        int   n;
        logic early_we;
        n        = 0;
        early_we = 1'b0;
        exe_i_hilowe = 1'b1;
        set_op(ALUTYPE_NOP, ALU_DIV, sgn, a, b);
        #1;
        while (exe_o_stallreq && n < 200) begin
            if (exe_o_hilowe) early_we = 1'b1;
            next_cycle();
            n++;
            if (n == corrupt_at) begin
                exe_i_src1 = 32'h1234_5678;
                exe_i_src2 = 32'h0000_0005;
                #1;
            end
        end
        check({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
        check({tag, "_early_hilowe"}, 64'(early_we), 64'd0);
        check({tag, "_hilo"}, exe_o_hilo, exp_hilo);
        check({tag, "_hilowe"}, 64'(exe_o_hilowe), 64'd1);
        next_cycle();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        exe_i_rfwe    = 1'b1;
        exe_i_rfwa    = 5'd17;
        exe_i_hilowe  = 1'b1;
        exe_i_dm2rf   = 1'b1;
        exe_i_dmdin   = 32'hCAFE_F00D;
        exe_i_memop   = '{load: 1'b1, store: 1'b0, size: 2'b10, sext: 1'b1};
        hi_i          = 32'hDEAD_BEEF;
        lo_i          = 32'h1234_5678;
        exe_i_aluop   = '{sign: 1'b0, op: ALU_DIV};
        set_op(ALUTYPE_NOP, ALU_DIV, 1'b0, 32'd10, 32'd3);

        // Reset with a DIV presented: no stall, no HI/LO write, passthrough live.
        #1;
        check("rst_stallreq", 64'(exe_o_stallreq), 64'd0);
        check("rst_hilowe", 64'(exe_o_hilowe), 64'd0);
        check("rst_rfwa_pass", 64'(exe_o_rfwa), 64'd17);
        check("pass_dmdin", 64'(exe_o_dmdin), 64'hCAFE_F00D);
        check("pass_memop", 64'(exe_o_memop), 64'(exe_i_memop));
        check("pass_ctl", 64'({exe_o_rfwe, exe_o_dm2rf}), 64'd3);
        next_cycle();
        set_op(ALUTYPE_NOP, ALU_EMPTY, 1'b0, 32'd0, 32'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("idle_stallreq", 64'(exe_o_stallreq), 64'd0);
        check("empty_wd", 64'(exe_o_wd), 64'd0);
        check("empty_hilowe", 64'(exe_o_hilowe), 64'd0);
        next_cycle();

        set_op(ALUTYPE_ARITH, ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1);
        #1;
        check("add_stallreq", 64'(exe_o_stallreq), 64'd0);
        alu("add_wrap",  ALUTYPE_ARITH, ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        alu("sub",       ALUTYPE_ARITH, ALU_SUB, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu("lt_signed", ALUTYPE_ARITH, ALU_LT,  1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu("lt_unsign", ALUTYPE_ARITH, ALU_LT,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu("and",       ALUTYPE_LOGIC, ALU_AND, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu("or",        ALUTYPE_LOGIC, ALU_OR,  1'b0, 32'h0F0F_0000, 32'h0000_0F0F, 32'h0F0F_0F0F);
        alu("xor",       ALUTYPE_LOGIC, ALU_XOR, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5);
        alu("nor",       ALUTYPE_LOGIC, ALU_NOR, 1'b0, 32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0);
        alu("sra",       ALUTYPE_SHIFT, ALU_RA,  1'b0, 32'd4, 32'h8000_0000, 32'hF800_0000);
        alu("srl",       ALUTYPE_SHIFT, ALU_RL,  1'b0, 32'd4, 32'h8000_0000, 32'h0800_0000);
        alu("sll_amt36", ALUTYPE_SHIFT, ALU_LL,  1'b0, 32'd36, 32'd1, 32'h0000_0010);
        alu("move_hi",   ALUTYPE_MOVE,  ALU_HI,  1'b0, 32'd0, 32'd0, 32'hDEAD_BEEF);
        alu("move_lo",   ALUTYPE_MOVE,  ALU_LO,  1'b0, 32'd0, 32'd0, 32'h1234_5678);

        exe_i_hilowe = 1'b1;
        set_op(ALUTYPE_NOP, ALU_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5);
        #1;
        check("mult_s_hilo", exe_o_hilo, 64'hFFFF_FFFF_FFFF_FFF1);
        check("mult_s_hilowe", 64'(exe_o_hilowe), 64'd1);
        check("mult_s_stall", 64'(exe_o_stallreq), 64'd0);
        next_cycle();
        set_op(ALUTYPE_NOP, ALU_MULT, 1'b0, 32'hFFFF_FFFF, 32'd2);
        #1;
        check("mult_u_hilo", exe_o_hilo, 64'h0000_0001_FFFF_FFFE);
        next_cycle();

        // Back-to-back DIVs, the second one starting right after DONE.
        run_div("div_neg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, -1);
        run_div("div_7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, -1);
        run_div("div_by0", 1'b0, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 1, -1);
        run_div("div_hold", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 5);

        set_op(ALUTYPE_NOP, ALU_EMPTY, 1'b0, 32'd0, 32'd0);
        #1;
        check("post_div_idle", 64'(exe_o_stallreq), 64'd0);
        next_cycle();

        // Abort a divide mid-iteration (count=10) with reset.
        set_op(ALUTYPE_NOP, ALU_DIV, 1'b0, 32'd50, 32'd5);
        repeat (11) next_cycle();
        check("mid_busy_stall", 64'(exe_o_stallreq), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", 64'(exe_o_stallreq), 64'd0);
        check("mid_rst_hilowe", 64'(exe_o_hilowe), 64'd0);
        next_cycle();
        rst = 1'b0;
        set_op(ALUTYPE_NOP, ALU_EMPTY, 1'b0, 32'd0, 32'd0);
        #1;
        check("after_rst_idle", 64'(exe_o_stallreq), 64'd0);
        next_cycle();
        run_div("div_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_exe.md
STAGE_EXE -- requirements
Module: stage_exe

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 exe_i_alutype  in  alutype_enum  operation class from the ID/EXE register: NOP, ARITH, LOGIC, MOVE, SHIFT.
REQ-004 exe_i_aluop  in  aluop_struct  sub-op and .sign flag.
REQ-005 exe_i_src1, exe_i_src2  in  32 each  operands; src1[4:0] is the shift amount for SHIFT.
REQ-006 exe_i_rfwe, exe_i_rfwa, exe_i_hilowe, exe_i_dm2rf, exe_i_dmdin, exe_i_memop  in  1/reg_enum/1/1/32/memop_struct  passthrough controls.
REQ-007 hi_i, lo_i  in  32 each  current HI/LO architectural values, used by MOVE.
REQ-008 exe_o_rfwe, exe_o_rfwa, exe_o_dm2rf, exe_o_dmdin, exe_o_memop  out  as inputs  passthrough, combinational.
REQ-009 exe_o_wd  out  32  ALU result; for loads and stores it is the memory address.
REQ-010 exe_o_hilowe  out  1  HI/LO write enable; exe_o_hilo  out  64  {hi,lo} write data.
REQ-011 exe_o_stallreq  out  1  pipeline stall request to the hazard/stall controller.

Function
REQ-012 ARITH: ADD gives src1+src2 modulo 2^32; SUB gives src1-src2; LT gives 1 if src1<src2, signed when aluop.sign=1, otherwise unsigned, and 0 otherwise. No overflow trap.
REQ-013 LOGIC: AND, OR, XOR and NOR are bitwise on src1/src2.
REQ-014 SHIFT: LL gives src2<<src1[4:0]; RL is a logical right shift; RA is an arithmetic right shift. src1[31:5] is ignored.
REQ-015 MOVE: HI gives exe_o_wd=hi_i; LO gives exe_o_wd=lo_i.
REQ-016 NOP/MULT: exe_o_hilo = src1*src2, 64-bit, signed when aluop.sign=1; single cycle; exe_o_hilowe=exe_i_hilowe; exe_o_stallreq=0.
REQ-017 NOP with mult_op=ALU_EMPTY: exe_o_wd=0 and exe_o_hilowe=0.
REQ-018 NOP/DIV uses a three-state FSM: IDLE, BUSY, DONE.
REQ-019 IDLE with a DIV present: load the operands (absolute values if signed), set count=0, go to BUSY, and assert exe_o_stallreq in that same cycle (combinational).
REQ-020 BUSY: one restoring quotient bit per cycle; count increments; exe_o_stallreq=1; go to DONE when count=31.
REQ-021 DONE: exe_o_stallreq=0; exe_o_hilo={remainder,quotient}; exe_o_hilowe=exe_i_hilowe; next state IDLE.
REQ-022 DIV total: exe_o_stallreq is high for exactly 33 consecutive cycles and the result is valid in the 34th cycle.
REQ-023 Signed DIV: quotient is negated if the operand signs differ; remainder takes the sign of the dividend (truncating division).
REQ-024 Divide by zero: IDLE goes directly to DONE (stallreq high for 1 cycle); hi=src1; lo=32'hFFFF_FFFF.
REQ-025 exe_o_hilowe=0 in IDLE and BUSY for DIV, so HI/LO is never written with a partial result.
REQ-026 Back-to-back DIVs: the second DIV starts from IDLE in the cycle after DONE.
REQ-027 Operands are captured at start; input changes during BUSY do not affect the result.

Reset
REQ-028 rst=1 forces state=IDLE, count=0 and all divider registers to 0, including mid-BUSY; the in-flight DIV is abandoned.
REQ-029 While rst=1, exe_o_stallreq=0 and exe_o_hilowe=0; the combinational outputs follow the inputs.

Structure
REQ-030 mips_cpu_pkg holds alutype_enum, aluop_struct, memop_struct and a new div_state_enum (IDLE, BUSY, DONE).
REQ-031 mips_cpu_pkg also holds DIV_CYCLES=32.
REQ-032 The iterative divider is one sub-module, div_iter.
REQ-033 div_iter ports: clk, rst, start, sign, dividend, divisor, busy, done, quotient, remainder.
REQ-034 stage_exe instantiates div_iter; all other logic in stage_exe is combinational.

Verification
REQ-035 ARITH/ADD with src1=32'h7FFF_FFFF, src2=1 -> exe_o_wd=32'h8000_0000, stallreq=0.
REQ-036 ARITH/LT, src1=32'hFFFF_FFFF, src2=1 -> wd=1 with sign=1; wd=0 with sign=0.
REQ-037 SHIFT/RA with src1=4, src2=32'h8000_0000 -> wd=32'hF800_0000; SHIFT/LL with src1=36 (shift amount 4), src2=1 -> wd=32'h10.
REQ-038 Signed MULT, src1=-3, src2=5, hilowe=1 -> hilo=64'hFFFF_FFFF_FFFF_FFF1, stallreq=0.
REQ-039 Signed DIV, src1=-7, src2=2 -> stallreq high for 33 cycles, then hilo={32'hFFFF_FFFF, 32'hFFFF_FFFD}, hilowe=1 for 1 cycle.
REQ-040 Unsigned DIV 100/0 -> stallreq for 1 cycle, then hi=100, lo=32'hFFFF_FFFF.
REQ-041 rst pulse at BUSY count=10 -> next cycle stallreq=0 and state IDLE; a following DIV 9/3 completes correctly (lo=3, hi=0).
